// File: rtl/mips_regfile_mp_pkg.sv
// Shared defines and types for the multi-port ID-stage register file.
`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif
`ifndef MIPS_RFREG_NUM
`define MIPS_RFREG_NUM 32
`endif
`ifndef MIPS_RFIDX_WIDTH
`define MIPS_RFIDX_WIDTH 5
`endif
`ifndef MIPS_RF_ST_INIT
`define MIPS_RF_ST_INIT 1'b0
`endif
`ifndef MIPS_RF_ST_READY
`define MIPS_RF_ST_READY 1'b1
`endif

package mips_regfile_mp_pkg;

  typedef enum logic {
    RF_INIT  = `MIPS_RF_ST_INIT,
    RF_READY = `MIPS_RF_ST_READY
  } rf_state_e;

endpackage

// File: rtl/dff_ce.sv
// Plain clock-enabled flop bank without reset; used as register storage.
module dff_ce #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (ce) q <= d;
  end

endmodule

// File: rtl/mips_rf_rdport.sv
// One combinational read port: stored value, optional same-cycle bypass, zero register.
module mips_rf_rdport #(
  parameter int DW       = 32,
  parameter int NREG     = 32,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int IW       = $clog2(NREG)
) (
  input  logic               ready,
  input  logic [IW-1:0]      rd_idx,
  input  logic [NREG*DW-1:0] rf_flat,
  input  logic [NWR-1:0]     wb_en,
  input  logic [NWR*IW-1:0]  wb_idx,
  input  logic [NWR*DW-1:0]  wb_dat,
  output logic [DW-1:0]      rd_dat
);

  always_comb begin
    rd_dat = '0;
    for (int r = 0; r < NREG; r++) begin
      if (rd_idx == IW'(r)) rd_dat = rf_flat[r*DW +: DW];
    end
    // Ascending scan so the highest-numbered matching lane is the one that sticks.
    if (BYPASS != 0) begin
      for (int l = 0; l < NWR; l++) begin
        if (wb_en[l] && (wb_idx[l*IW +: IW] == rd_idx)) rd_dat = wb_dat[l*DW +: DW];
      end
    end
    if (!ready || ((ZERO_REG != 0) && (rd_idx == '0))) rd_dat = '0;
  end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port register file: post-reset clear sweep, prioritised write lanes, N read ports.
import mips_regfile_mp_pkg::*;

`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif
`ifndef MIPS_RFREG_NUM
`define MIPS_RFREG_NUM 32
`endif

// state    | meaning
// RF_INIT  | clear sweep running, one register per edge; writes dropped, reads return 0
// RF_READY | normal operation, writes accepted, rf_rdy high
module mips_regfile_mp #(
  parameter int DW       = `MIPS_DATA_WIDTH,
  parameter int NREG     = `MIPS_RFREG_NUM,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int IW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*IW-1:0] rd_idx,
  output logic [NRD*DW-1:0] rd_dat,
  input  logic [NWR-1:0]    wb_en,
  input  logic [NWR*IW-1:0] wb_idx,
  input  logic [NWR*DW-1:0] wb_dat,
  output logic              rf_rdy
);

  rf_state_e     state_q, state_d;
  logic [IW-1:0] clr_idx_q, clr_idx_d;
  logic          rf_rdy_q, rf_rdy_d;

  logic [NREG*DW-1:0] rf_flat;
  logic               ready;
  logic               clr_ok;
  logic               wr_ok;

  assign ready  = (state_q == RF_READY);
  assign rf_rdy = rf_rdy_q;
  // Storage is left alone on a reset edge, so both write sources are gated by rst.
  assign clr_ok = (state_q == RF_INIT) && !rst;
  assign wr_ok  = ready && !rst;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    rf_rdy_d  = rf_rdy_q;
    if (state_q == RF_INIT) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == IW'(NREG - 1)) begin
        state_d  = RF_READY;
        rf_rdy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_INIT;
      clr_idx_q <= '0;
      rf_rdy_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rf_rdy_q  <= rf_rdy_d;
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    logic          ce;
    logic [DW-1:0] d;

    always_comb begin
      ce = 1'b0;
      d  = '0;
      if (clr_ok && (clr_idx_q == IW'(r))) begin
        ce = 1'b1;
      end else if (wr_ok && !((ZERO_REG != 0) && (r == 0))) begin
        for (int l = 0; l < NWR; l++) begin
          if (wb_en[l] && (wb_idx[l*IW +: IW] == IW'(r))) begin
            ce = 1'b1;
            d  = wb_dat[l*DW +: DW];
          end
        end
      end
    end

    dff_ce #(.W(DW)) u_dff (
      .clk (clk),
      .ce  (ce),
      .d   (d),
      .q   (rf_flat[r*DW +: DW])
    );
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    mips_rf_rdport #(
      .DW       (DW),
      .NREG     (NREG),
      .NWR      (NWR),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG),
      .IW       (IW)
    ) u_rdport (
      .ready   (ready),
      .rd_idx  (rd_idx[p*IW +: IW]),
      .rf_flat (rf_flat),
      .wb_en   (wb_en),
      .wb_idx  (wb_idx),
      .wb_dat  (wb_dat),
      .rd_dat  (rd_dat[p*DW +: DW])
    );
  end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Randomised bench for mips_regfile_mp: two configurations against an array-based reference.
module tb_mips_regfile_mp;

  localparam int NREG = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_idx = '0;
  logic [1:0]  wb_en = '0;
  logic [9:0]  wb_idx = '0;
  logic [63:0] wb_dat = '0;
  logic [63:0] rd_dat_a, rd_dat_b;
  logic        rf_rdy_a, rf_rdy_b;

  always #5 clk = ~clk;

  // a: bypass on, zero register on
  mips_regfile_mp #(.DW(32), .NREG(NREG), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) u_dut_a (
    .clk (clk), .rst (rst), .rd_idx (rd_idx), .rd_dat (rd_dat_a),
    .wb_en (wb_en), .wb_idx (wb_idx), .wb_dat (wb_dat), .rf_rdy (rf_rdy_a)
  );

  // b: bypass off, register 0 ordinary
  mips_regfile_mp #(.DW(32), .NREG(NREG), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(0)) u_dut_b (
    .clk (clk), .rst (rst), .rd_idx (rd_idx), .rd_dat (rd_dat_b),
    .wb_en (wb_en), .wb_idx (wb_idx), .wb_dat (wb_dat), .rf_rdy (rf_rdy_b)
  );

  logic [31:0] mem_a [NREG];
  logic [31:0] mem_b [NREG];
  int          edges_since_rst;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%08h exp=%08h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] exp_rd(input bit is_b, input logic [4:0] idx);
    if (edges_since_rst < NREG) return 32'h0;
    if (!is_b) begin
      if (idx == 5'd0) return 32'h0;
      for (int l = 1; l >= 0; l--)
        if (wb_en[l] && wb_idx[l*5 +: 5] == idx) return wb_dat[l*32 +: 32];
      return mem_a[idx];
    end
    return mem_b[idx];
  endfunction

  // Reference behaviour at a rising edge, using the inputs held across it.
  task automatic model_edge();
    if (rst) begin
      edges_since_rst = 0;
    end else if (edges_since_rst < NREG) begin
      edges_since_rst++;
      if (edges_since_rst == NREG)
        for (int r = 0; r < NREG; r++) begin
          mem_a[r] = 32'h0;
          mem_b[r] = 32'h0;
        end
    end else begin
      for (int l = 0; l < 2; l++)
        if (wb_en[l]) begin
          if (wb_idx[l*5 +: 5] != 5'd0) mem_a[wb_idx[l*5 +: 5]] = wb_dat[l*32 +: 32];
          mem_b[wb_idx[l*5 +: 5]] = wb_dat[l*32 +: 32];
        end
    end
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step();
    logic [4:0] idx;
    #1;
    chk("rf_rdy_a", {31'd0, rf_rdy_a}, {31'd0, edges_since_rst >= NREG});
    chk("rf_rdy_b", {31'd0, rf_rdy_b}, {31'd0, edges_since_rst >= NREG});
    for (int p = 0; p < 2; p++) begin
      idx = rd_idx[p*5 +: 5];
      chk($sformatf("rd_a p%0d r%0d", p, idx), rd_dat_a[p*32 +: 32], exp_rd(1'b0, idx));
      chk($sformatf("rd_b p%0d r%0d", p, idx), rd_dat_b[p*32 +: 32], exp_rd(1'b1, idx));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] en, input logic [4:0] i0, input logic [31:0] d0,
                       input logic [4:0] i1, input logic [31:0] d1,
                       input logic [4:0] r0, input logic [4:0] r1);
    wb_en  = en;
    wb_idx = {i1, i0};
    wb_dat = {d1, d0};
    rd_idx = {r1, r0};
  endtask

  task automatic idle_read(input logic [4:0] r0, input logic [4:0] r1);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, r0, r1);
  endtask

  initial begin
    edges_since_rst = 0;
    for (int r = 0; r < NREG; r++) begin
      mem_a[r] = 32'h0;
      mem_b[r] = 32'h0;
    end
    // First reset edge unchecked: the state before it is unknown.
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = 1'b0;

    // Sweep interrupted at count 10, then a full sweep with writes to r4 that must be dropped.
    for (int i = 0; i < 10; i++) begin
      idle_read(5'(i), 5'd4);
      step();
    end
    rst = 1'b1;
    idle_read(5'd4, 5'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      drive(2'b01, 5'd4, 32'h0BAD0000 + 32'(i), 5'd0, 32'h0, 5'd4, 5'(i));
      step();
    end
    for (int r = 0; r < NREG; r += 2) begin
      idle_read(5'(r), 5'(r + 1));
      step();
    end

    // Two lanes, distinct targets.
    drive(2'b11, 5'd5, 32'hDEADBEEF, 5'd7, 32'h12345678, 5'd5, 5'd7);
    step();
    idle_read(5'd5, 5'd7);
    step();
    // Collision on r9, lane 1 wins.
    drive(2'b11, 5'd9, 32'h1, 5'd9, 32'h2, 5'd9, 5'd5);
    step();
    idle_read(5'd9, 5'd7);
    step();
    // Writes to r0.
    drive(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 5'd0, 5'd0);
    step();
    idle_read(5'd0, 5'd9);
    step();
    // r3 written while being read.
    drive(2'b10, 5'd0, 32'h0, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
    step();
    idle_read(5'd3, 5'd0);
    step();

    // Reset from READY with r4 holding a value.
    drive(2'b01, 5'd4, 32'h55, 5'd0, 32'h0, 5'd4, 5'd4);
    step();
    idle_read(5'd4, 5'd3);
    step();
    rst = 1'b1;
    drive(2'b10, 5'd0, 32'h0, 5'd6, 32'h77, 5'd4, 5'd6);
    step();
    rst = 1'b0;
    for (int i = 0; i < NREG + 2; i++) begin
      idle_read(5'd4, 5'd6);
      step();
    end

    // Randomised traffic with small index ranges to provoke collisions and bypass hits.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] i0, i1, r0, r1;
      i0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      i1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      r0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      drive(2'($urandom), i0, $urandom, i1, $urandom, r0, r1);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
